// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if
//   Signal bundle around mem_port_arb: the IFU and LSU request/response
//   channels, the single RAM port, and the busy status.
//   Signal names keep the arbiter-relative i_/o_ prefixes.
//   slave  modport : arbiter view (drives o_*, samples i_*)
//   master modport : environment view (IFU, LSU, RAM wrapper)
//   Parameters: ADDR_WIDTH, DATA_WIDTH (byte mask is DATA_WIDTH/8 wide).
interface mem_port_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // IFU channel (read-only)
  logic                  i_ifu_req_valid;
  logic                  o_ifu_req_ready;
  logic [ADDR_WIDTH-1:0] i_ifu_req_addr;
  logic                  o_ifu_rsp_valid;
  logic [DATA_WIDTH-1:0] o_ifu_rsp_data;
  logic                  o_ifu_rsp_err;

  // LSU channel (loads and stores)
  logic                  i_lsu_req_valid;
  logic                  o_lsu_req_ready;
  logic [ADDR_WIDTH-1:0] i_lsu_req_addr;
  logic                  i_lsu_req_wr_en;
  logic [DATA_WIDTH-1:0] i_lsu_req_wr_data;
  logic [MASK_WIDTH-1:0] i_lsu_req_wr_mask;
  logic                  o_lsu_rsp_valid;
  logic [DATA_WIDTH-1:0] o_lsu_rsp_data;
  logic                  o_lsu_rsp_err;

  // RAM port
  logic                  o_mem_req_valid;
  logic                  i_mem_req_ready;
  logic [ADDR_WIDTH-1:0] o_mem_req_addr;
  logic                  o_mem_req_wr_en;
  logic [DATA_WIDTH-1:0] o_mem_req_wr_data;
  logic [MASK_WIDTH-1:0] o_mem_req_wr_mask;
  logic                  i_mem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_mem_rsp_data;

  logic                  o_arb_busy;

  modport slave (
    input  i_ifu_req_valid, i_ifu_req_addr,
    output o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rsp_data, o_ifu_rsp_err,
    input  i_lsu_req_valid, i_lsu_req_addr, i_lsu_req_wr_en,
           i_lsu_req_wr_data, i_lsu_req_wr_mask,
    output o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data, o_lsu_rsp_err,
    output o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_en,
           o_mem_req_wr_data, o_mem_req_wr_mask,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    output o_arb_busy
  );

  modport master (
    output i_ifu_req_valid, i_ifu_req_addr,
    input  o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rsp_data, o_ifu_rsp_err,
    output i_lsu_req_valid, i_lsu_req_addr, i_lsu_req_wr_en,
           i_lsu_req_wr_data, i_lsu_req_wr_mask,
    input  o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data, o_lsu_rsp_err,
    input  o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_en,
           o_mem_req_wr_data, o_mem_req_wr_mask,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    input  o_arb_busy
  );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Shares the single data RAM port between the IFU (reads) and the LSU
//   (loads/stores). Round-robin arbitration, one outstanding transaction,
//   one-cycle response pulse back to the requester that won.
//   Ports:
//     i_sys_clk : clock, rising edge
//     i_sys_rst : asynchronous active-high reset
//     bus       : mem_port_arb_if.slave (IFU, LSU, RAM port, o_arb_busy)
//   Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES (1..255).
//   Build option: define MEM_ARB_TIMEOUT_EN to abort a transaction after
//   TIMEOUT_CYCLES cycles in GRANT/WAIT_RSP and answer with err=1.
module mem_port_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           i_sys_clk,
  input logic           i_sys_rst,
  mem_port_arb_if.slave bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arb: TIMEOUT_CYCLES must be within 1..255");
  end

  logic [1:0]            r_state;
  logic                  r_owner;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [MASK_WIDTH-1:0] r_wr_mask;
  logic                  r_ifu_rsp_valid;
  logic                  r_lsu_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;

  logic ifu_win;
  logic lsu_win;
  logic accept;
  logic rsp_done;
  logic tmo_hit;

  // Readiness is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (r_state == ST_IDLE && !i_sys_rst) begin
      if (bus.i_ifu_req_valid && bus.i_lsu_req_valid) begin
        ifu_win = (r_last_grant == OWN_LSU);
        lsu_win = (r_last_grant == OWN_IFU);
      end else begin
        ifu_win = bus.i_ifu_req_valid;
        lsu_win = bus.i_lsu_req_valid;
      end
    end
  end

  assign accept   = ifu_win | lsu_win;
  assign rsp_done = (r_state == ST_WAIT_RSP) && bus.i_mem_rsp_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  // Counter holds (cycles already spent busy); the abort fires in the
  // TIMEOUT_CYCLES-th busy cycle unless the response lands in that cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tmo_cnt;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_tmo_cnt <= '0;
    end else if (accept) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_IDLE) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  assign tmo_hit = (r_state != ST_IDLE) && (r_tmo_cnt == TMO_LAST) && !rsp_done;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state         <= ST_IDLE;
      r_owner         <= OWN_IFU;
      r_last_grant    <= OWN_LSU;
      r_addr          <= '0;
      r_wr_en         <= 1'b0;
      r_wr_data       <= '0;
      r_wr_mask       <= '0;
      r_ifu_rsp_valid <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_err       <= 1'b0;
    end else begin
      r_ifu_rsp_valid <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (accept) begin
            r_owner      <= lsu_win ? OWN_LSU : OWN_IFU;
            r_last_grant <= lsu_win ? OWN_LSU : OWN_IFU;
            if (lsu_win) begin
              r_addr    <= bus.i_lsu_req_addr;
              r_wr_en   <= bus.i_lsu_req_wr_en;
              r_wr_data <= bus.i_lsu_req_wr_data;
              r_wr_mask <= bus.i_lsu_req_wr_mask;
            end else begin
              r_addr    <= bus.i_ifu_req_addr;
              r_wr_en   <= 1'b0;
              r_wr_data <= '0;
              r_wr_mask <= '0;
            end
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (tmo_hit) begin
            r_ifu_rsp_valid <= (r_owner == OWN_IFU);
            r_lsu_rsp_valid <= (r_owner == OWN_LSU);
            r_rsp_err       <= 1'b1;
            r_state         <= ST_IDLE;
          end else if (bus.i_mem_req_ready) begin
            r_state <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_done) begin
            r_ifu_rsp_valid <= (r_owner == OWN_IFU);
            r_lsu_rsp_valid <= (r_owner == OWN_LSU);
            r_rsp_data      <= r_wr_en ? '0 : bus.i_mem_rsp_data;
            r_state         <= ST_IDLE;
          end else if (tmo_hit) begin
            r_ifu_rsp_valid <= (r_owner == OWN_IFU);
            r_lsu_rsp_valid <= (r_owner == OWN_LSU);
            r_rsp_err       <= 1'b1;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ifu_req_ready   = ifu_win;
  assign bus.o_lsu_req_ready   = lsu_win;

  assign bus.o_mem_req_valid   = (r_state == ST_GRANT);
  assign bus.o_mem_req_addr    = r_addr;
  assign bus.o_mem_req_wr_en   = r_wr_en;
  assign bus.o_mem_req_wr_data = r_wr_data;
  assign bus.o_mem_req_wr_mask = r_wr_mask;

  assign bus.o_ifu_rsp_valid   = r_ifu_rsp_valid;
  assign bus.o_ifu_rsp_data    = r_ifu_rsp_valid ? r_rsp_data : '0;
  assign bus.o_ifu_rsp_err     = r_ifu_rsp_valid & r_rsp_err;
  assign bus.o_lsu_rsp_valid   = r_lsu_rsp_valid;
  assign bus.o_lsu_rsp_data    = r_lsu_rsp_valid ? r_rsp_data : '0;
  assign bus.o_lsu_rsp_err     = r_lsu_rsp_valid & r_rsp_err;

  assign bus.o_arb_busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb
//   Self-checking bench for mem_port_arb: transaction-level reference model
//   compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arb;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder knobs
  int          rdy_pct   = 100;
  int          dly_min   = 0;
  int          dly_max   = 0;
  bit          rsp_en    = 1'b1;
  bit          spur_en   = 1'b0;
  int          ready_low = 0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  bit          inject_rsp = 1'b0;

  // RAM side: answers each accepted request after a programmable delay.
  initial begin
    bit pend;
    int cnt;
    pend = 1'b0;
    cnt  = 0;
    bus.i_mem_req_ready = 1'b0;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_mem_req_valid && bus.i_mem_req_ready) begin
        pend = rsp_en;
        cnt  = $urandom_range(dly_max, dly_min);
      end
      @(posedge clk);
      #1;
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rsp_data  = '0;
      if (pend && cnt == 0) begin
        pend = 1'b0;
        bus.i_mem_rsp_valid = 1'b1;
        bus.i_mem_rsp_data  = use_fixed ? fixed_data : $urandom;
      end else if (pend) begin
        cnt--;
      end else if (inject_rsp || (spur_en && $urandom_range(7, 0) == 0)) begin
        inject_rsp = 1'b0;
        bus.i_mem_rsp_valid = 1'b1;
        bus.i_mem_rsp_data  = $urandom;
      end
      if (bus.o_mem_req_valid) begin
        if (ready_low > 0) begin
          bus.i_mem_req_ready = 1'b0;
          ready_low--;
        end else begin
          bus.i_mem_req_ready = ($urandom_range(99, 0) < rdy_pct);
        end
      end else begin
        bus.i_mem_req_ready = 1'b0;
      end
    end
  end

  // Reference model: one transaction record, checked on every falling edge.
  initial begin
    bit          busy, issued, own, last;
    bit          p_ifu, p_lsu, p_err;
    logic [31:0] p_data;
    logic [31:0] m_addr, m_wdata;
    bit          m_wr;
    logic [3:0]  m_mask;
    int          age;
    bit          e_ri, e_rl, done, tmo;
    busy = 0; issued = 0; own = 0; last = 1;
    p_ifu = 0; p_lsu = 0; p_err = 0; p_data = '0;
    m_addr = '0; m_wdata = '0; m_wr = 0; m_mask = '0; age = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ready", {bus.o_ifu_req_ready, bus.o_lsu_req_ready}, 2'b00);
        chk("rst_mem", {bus.o_mem_req_valid, bus.o_mem_req_addr, bus.o_mem_req_wr_en,
                        bus.o_mem_req_wr_data, bus.o_mem_req_wr_mask}, '0);
        chk("rst_rsp", {bus.o_ifu_rsp_valid, bus.o_ifu_rsp_err, bus.o_ifu_rsp_data,
                        bus.o_lsu_rsp_valid, bus.o_lsu_rsp_err, bus.o_lsu_rsp_data}, '0);
        chk("rst_busy", bus.o_arb_busy, 1'b0);
        busy = 0; issued = 0; own = 0; last = 1;
        p_ifu = 0; p_lsu = 0; p_err = 0; p_data = '0; age = 0;
      end else begin
        e_ri = 0;
        e_rl = 0;
        if (!busy) begin
          if (bus.i_ifu_req_valid && bus.i_lsu_req_valid) begin
            e_ri = last;
            e_rl = !last;
          end else begin
            e_ri = bus.i_ifu_req_valid;
            e_rl = bus.i_lsu_req_valid;
          end
        end
        chk("ifu_req_ready", bus.o_ifu_req_ready, e_ri);
        chk("lsu_req_ready", bus.o_lsu_req_ready, e_rl);
        chk("mem_req_valid", bus.o_mem_req_valid, busy && !issued);
        if (busy && !issued)
          chk("mem_req_fields", {bus.o_mem_req_addr, bus.o_mem_req_wr_en,
                                 bus.o_mem_req_wr_data, bus.o_mem_req_wr_mask},
              {m_addr, m_wr, m_wdata, m_mask});
        chk("ifu_rsp", {bus.o_ifu_rsp_valid, bus.o_ifu_rsp_err, bus.o_ifu_rsp_data},
            {p_ifu, p_ifu & p_err, p_ifu ? p_data : 32'h0});
        chk("lsu_rsp", {bus.o_lsu_rsp_valid, bus.o_lsu_rsp_err, bus.o_lsu_rsp_data},
            {p_lsu, p_lsu & p_err, p_lsu ? p_data : 32'h0});
        chk("arb_busy", bus.o_arb_busy, busy);

        // Advance to what the next cycle must look like.
        p_ifu = 0; p_lsu = 0; p_err = 0; p_data = '0;
        if (busy) begin
          done = issued && bus.i_mem_rsp_valid;
          tmo  = 0;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo = !done && (age + 1 == TMO);
`endif
          if (done) begin
            p_ifu  = (own == 0);
            p_lsu  = (own == 1);
            p_data = m_wr ? 32'h0 : bus.i_mem_rsp_data;
            busy   = 0;
          end else if (tmo) begin
            p_ifu = (own == 0);
            p_lsu = (own == 1);
            p_err = 1;
            busy  = 0;
          end else if (!issued && bus.i_mem_req_ready) begin
            issued = 1;
          end
          age++;
        end else if (e_ri || e_rl) begin
          busy = 1; issued = 0; age = 0;
          own  = e_rl;
          last = e_rl;
          if (e_rl) begin
            m_addr = bus.i_lsu_req_addr; m_wr = bus.i_lsu_req_wr_en;
            m_wdata = bus.i_lsu_req_wr_data; m_mask = bus.i_lsu_req_wr_mask;
          end else begin
            m_addr = bus.i_ifu_req_addr; m_wr = 0; m_wdata = '0; m_mask = '0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_arb_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", bus.o_arb_busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus and directed expectations
  initial begin
    int gseq[4];
    int ng;
    rst = 1'b1;
    bus.i_ifu_req_valid   = 1'b1;
    bus.i_ifu_req_addr    = 32'h8000_0100;
    bus.i_lsu_req_valid   = 1'b1;
    bus.i_lsu_req_addr    = 32'h8000_2000;
    bus.i_lsu_req_wr_en   = 1'b0;
    bus.i_lsu_req_wr_data = '0;
    bus.i_lsu_req_wr_mask = '0;
    for (int i = 0; i < 4; i++) gseq[i] = -1;
    ng = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin with both requesters always asking
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.o_ifu_req_ready) begin gseq[ng] = 0; ng++; end
      else if (bus.o_lsu_req_ready) begin gseq[ng] = 1; ng++; end
      if (ng == 4) break;
      @(posedge clk);
      #1;
    end
    chk("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), gseq[i], i % 2);
    @(posedge clk);
    #1;
    bus.i_ifu_req_valid = 1'b0;
    bus.i_lsu_req_valid = 1'b0;
    wait_idle();

    // IFU read, three-cycle latency to the response pulse
    use_fixed  = 1'b1;
    fixed_data = 32'h0000_0013;
    bus.i_ifu_req_valid = 1'b1;
    bus.i_ifu_req_addr  = 32'h8000_0000;
    @(negedge clk);
    chk("rd_accept", {bus.o_ifu_req_ready, bus.o_lsu_req_ready}, 2'b10);
    @(posedge clk);
    #1 bus.i_ifu_req_valid = 1'b0;
    bus.i_ifu_req_addr = 32'h1234_5678;
    @(negedge clk);
    chk("rd_c1_req", {bus.o_mem_req_valid, bus.o_mem_req_addr, bus.o_mem_req_wr_en},
        {1'b1, 32'h8000_0000, 1'b0});
    @(negedge clk);
    chk("rd_c2_wait", {bus.o_arb_busy, bus.o_mem_req_valid, bus.o_ifu_rsp_valid}, 3'b100);
    @(negedge clk);
    chk("rd_c3_ifu_rsp", {bus.o_ifu_rsp_valid, bus.o_ifu_rsp_err, bus.o_ifu_rsp_data},
        {1'b1, 1'b0, 32'h0000_0013});
    chk("rd_c3_lsu_quiet", {bus.o_lsu_rsp_valid, bus.o_lsu_rsp_data}, '0);
    @(posedge clk);
    #1;
    wait_idle();

    // LSU store with memory back-pressure for 4 cycles
    ready_low = 4;
    bus.i_lsu_req_valid   = 1'b1;
    bus.i_lsu_req_addr    = 32'h8000_1004;
    bus.i_lsu_req_wr_en   = 1'b1;
    bus.i_lsu_req_wr_data = 32'hDEAD_BEEF;
    bus.i_lsu_req_wr_mask = 4'hF;
    @(negedge clk);
    chk("st_accept", {bus.o_ifu_req_ready, bus.o_lsu_req_ready}, 2'b01);
    @(posedge clk);
    #1 bus.i_lsu_req_valid = 1'b0;
    bus.i_lsu_req_addr    = $urandom;
    bus.i_lsu_req_wr_data = $urandom;
    bus.i_lsu_req_wr_mask = 4'h3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("st_req_c%0d", k),
          {bus.o_mem_req_valid, bus.o_mem_req_addr, bus.o_mem_req_wr_en,
           bus.o_mem_req_wr_data, bus.o_mem_req_wr_mask},
          {1'b1, 32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF});
    end
    @(negedge clk);
    chk("st_c6_req_low", bus.o_mem_req_valid, 1'b0);
    @(negedge clk);
    chk("st_lsu_rsp", {bus.o_lsu_rsp_valid, bus.o_lsu_rsp_err, bus.o_lsu_rsp_data},
        {1'b1, 1'b0, 32'h0});
    chk("st_ifu_quiet", bus.o_ifu_rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    wait_idle();

    // Reset while waiting for the response; the response arrives afterwards
    dly_min = 4;
    dly_max = 4;
    bus.i_ifu_req_valid = 1'b1;
    bus.i_ifu_req_addr  = 32'h8000_0040;
    @(posedge clk);
    #1 bus.i_ifu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rr_in_wait", {bus.o_arb_busy, bus.o_mem_req_valid}, 2'b10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", k),
          {bus.o_ifu_rsp_valid, bus.o_lsu_rsp_valid, bus.o_arb_busy}, 3'b000);
    end
    @(posedge clk);
    #1;
    dly_min = 0;
    dly_max = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // LSU load that memory never answers
    rsp_en = 1'b0;
    bus.i_lsu_req_valid = 1'b1;
    bus.i_lsu_req_addr  = 32'h8000_0800;
    bus.i_lsu_req_wr_en = 1'b0;
    @(posedge clk);
    #1 bus.i_lsu_req_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_busy_c%0d", k), {bus.o_arb_busy, bus.o_lsu_rsp_valid}, 2'b10);
    end
    @(negedge clk);
    chk("tmo_lsu_rsp", {bus.o_lsu_rsp_valid, bus.o_lsu_rsp_err, bus.o_lsu_rsp_data},
        {1'b1, 1'b1, 32'h0});
    inject_rsp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_late_drop%0d", k),
          {bus.o_ifu_rsp_valid, bus.o_lsu_rsp_valid, bus.o_arb_busy}, 3'b000);
    end
    @(posedge clk);
    #1;
    rsp_en = 1'b1;
`endif

    // Randomized traffic
    use_fixed = 1'b0;
    rdy_pct   = 70;
    dly_min   = 0;
    dly_max   = 3;
    spur_en   = 1'b1;
    for (int c = 0; c < 600; c++) begin
      bus.i_ifu_req_valid   = ($urandom_range(3, 0) != 0);
      bus.i_ifu_req_addr    = $urandom;
      bus.i_lsu_req_valid   = ($urandom_range(2, 0) != 0);
      bus.i_lsu_req_addr    = $urandom;
      bus.i_lsu_req_wr_en   = $urandom_range(1, 0);
      bus.i_lsu_req_wr_data = $urandom;
      bus.i_lsu_req_wr_mask = 4'($urandom_range(15, 0));
      @(posedge clk);
      #1;
    end
    bus.i_ifu_req_valid = 1'b0;
    bus.i_lsu_req_valid = 1'b0;
    spur_en = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbiter and sequencer that shares the core's single data RAM port between the IFU (instruction fetch, read-only) and the LSU (load/store from the EXU->LSU stage).
- Accepts one request at a time with round-robin arbitration.
- Drives the memory request and waits for the response, then routes a one-cycle response pulse back to the winning requester.
- Sits between the IFU/LSU stages and the RAM wrapper; only one transaction is ever outstanding.

Parameters:
ADDR_WIDTH, 32, address width of all request ports
DATA_WIDTH, 32, data width; byte-mask width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, cycles spent in GRANT+WAIT_RSP before abort (used only with MEM_ARB_TIMEOUT_EN); range 1..255

Ports:
i_sys_clk  in  1  clock; all state updates on the rising edge
i_sys_rst  in  1  asynchronous, active-high reset
i_ifu_req_valid  in  1  IFU read request
o_ifu_req_ready  out  1  IFU request accepted this cycle
i_ifu_req_addr  in  ADDR_WIDTH  IFU fetch address
o_ifu_rsp_valid  out  1  one-cycle IFU response pulse
o_ifu_rsp_data  out  DATA_WIDTH  IFU read data
o_ifu_rsp_err  out  1  IFU response error (timeout)
i_lsu_req_valid  in  1  LSU request
o_lsu_req_ready  out  1  LSU request accepted this cycle
i_lsu_req_addr  in  ADDR_WIDTH  LSU address
i_lsu_req_wr_en  in  1  1 = store, 0 = load
i_lsu_req_wr_data  in  DATA_WIDTH  store data
i_lsu_req_wr_mask  in  DATA_WIDTH/8  store byte enables
o_lsu_rsp_valid  out  1  one-cycle LSU response pulse (loads and stores)
o_lsu_rsp_data  out  DATA_WIDTH  load data (0 for stores)
o_lsu_rsp_err  out  1  LSU response error (timeout)
o_mem_req_valid  out  1  memory request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_req_addr  out  ADDR_WIDTH  memory address
o_mem_req_wr_en  out  1  memory write enable
o_mem_req_wr_data  out  DATA_WIDTH  memory write data
o_mem_req_wr_mask  out  DATA_WIDTH/8  memory byte enables
i_mem_rsp_valid  in  1  memory response (reads and writes)
i_mem_rsp_data  in  DATA_WIDTH  memory read data
o_arb_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, r_last_grant = LSU (so IFU wins the first tie), and all request, response and timeout registers cleared. Reset asserted mid-transaction aborts it silently; no response pulse is issued.
- FSM has three states: IDLE, GRANT, WAIT_RSP.
- IDLE:
  - Ready outputs are combinational on valid. o_ifu_req_ready = winner==IFU; o_lsu_req_ready = winner==LSU; at most one is high per cycle.
  - Winner: the sole valid requester; if both are valid, the one not equal to r_last_grant.
  - On accept: latch addr/wr_en/wr_data/wr_mask (IFU: wr_en=0, mask=0, data=0), latch owner, set r_last_grant=owner, go to GRANT.
  - Requesters must not make valid depend on ready.
- GRANT:
  - o_mem_req_valid=1 with the latched fields.
  - On i_mem_req_ready=1, go to WAIT_RSP; the request fields stay stable until then.
- WAIT_RSP:
  - o_mem_req_valid=0.
  - On i_mem_rsp_valid=1, register the data; the next cycle pulses owner's rsp_valid for exactly 1 cycle with data (stores: data forced 0), err=0. State returns to IDLE on the same edge the response is registered.
  - A new request can therefore be accepted in the same cycle the previous response pulse is visible.
- Latency with memory ready and responding immediately: accept at cycle 0, mem_req_valid in cycle 1, rsp captured in cycle 2, rsp pulse in cycle 3.
- i_mem_rsp_valid in IDLE or GRANT is ignored (dropped).
- Response outputs of the non-owner stay 0; data outputs are 0 whenever rsp_valid=0.
- o_arb_busy = (state != IDLE).

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on accept and increments each cycle in GRANT or WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES without completion, the FSM aborts to IDLE. Next cycle, the owner's rsp_valid=1, err=1, data=0.
  - A late i_mem_rsp_valid arriving in IDLE is dropped.
- Not defined: no counter, both rsp_err outputs tied 0, and the FSM waits indefinitely.

Test Plan:
- Reset with both valids high, release, memory always ready with rsp 1 cycle after request -> IFU granted first; LSU granted after the IFU response; grants then alternate IFU/LSU/IFU.
- IFU read addr 0x80000000, mem ready in cycle 1, rsp_data 0x00000013 in cycle 2 -> o_ifu_rsp_valid pulses in cycle 3 with data 0x00000013, err 0; o_lsu_rsp_valid stays 0.
- LSU store addr 0x80001004, data 0xDEADBEEF, mask 0xF, mem_req_ready held low 4 cycles -> o_mem_req_valid high with stable fields for 5 cycles; o_lsu_rsp_valid pulses with data 0.
- Async reset asserted while in WAIT_RSP, then mem rsp arrives after reset is released -> no response pulse, state IDLE, o_arb_busy 0.
- MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, memory never responds to an LSU load -> o_lsu_rsp_valid=1, err=1, data=0 one cycle after the 8th cycle; a later i_mem_rsp_valid is ignored.
